// File: rtl/ts_scurve_sequencer_pkg.sv
// ts_scurve_pkg: shared widths, timeout and scan FSM state type for the s-curve sequencer.
package ts_scurve_pkg;
    localparam int DAC_W    = 10;
    localparam int ACC_W    = 12;
    localparam int SETTLE_W = 8;
    localparam int STEP_W   = 4;
    localparam int TMO_CYC  = 16;
    typedef enum logic [2:0] {
        S_IDLE, S_SET_DAC, S_SETTLE, S_LAUNCH, S_WAIT_HI, S_WAIT_LO, S_EMIT, S_FINISH
    } scan_state_t;
endpackage

// File: rtl/ts_scurve_sequencer_if.sv
// ts_scurve_sequencer_if: config, accumulator and result signals of the s-curve sequencer.
// Fit result signals exist only when SCURVE_FIT_EN is defined.
interface ts_scurve_sequencer_if;
    import ts_scurve_pkg::*;
    logic                Start;
    logic                Abort;
    logic [DAC_W-1:0]    DacStart;
    logic [DAC_W-1:0]    DacStop;
    logic [STEP_W-1:0]   DacStep;
    logic [SETTLE_W-1:0] SettleCyc;
    logic [DAC_W-1:0]    DacCode;
    logic                AccStart;
    logic                AccBusy;
    logic [ACC_W-1:0]    Acc;
    logic                ResValid;
    logic                ResReady;
    logic [DAC_W-1:0]    ResDac;
    logic [ACC_W-1:0]    ResAcc;
    logic                Busy;
    logic                Done;
    logic                Err;
`ifdef SCURVE_FIT_EN
    logic                FitValid;
    logic [DAC_W-1:0]    FitDac;
`endif
    modport master (
        input  Start, Abort, DacStart, DacStop, DacStep, SettleCyc, AccBusy, Acc, ResReady,
`ifdef SCURVE_FIT_EN
        output FitValid, FitDac,
`endif
        output DacCode, AccStart, ResValid, ResDac, ResAcc, Busy, Done, Err
    );
    modport slave (
        output Start, Abort, DacStart, DacStop, DacStep, SettleCyc, AccBusy, Acc, ResReady,
`ifdef SCURVE_FIT_EN
        input  FitValid, FitDac,
`endif
        input  DacCode, AccStart, ResValid, ResDac, ResAcc, Busy, Done, Err
    );
endinterface

// File: rtl/ts_scurve_sequencer_fit.sv
// ts_scurve_fit: tracks the scan maximum and the first DAC after it whose count falls to half the maximum.
// Compiled only when SCURVE_FIT_EN is defined.
`ifdef SCURVE_FIT_EN
module ts_scurve_fit
    import ts_scurve_pkg::*;
(
    input  logic             clk_int,
    input  logic             RSTn_int,
    input  logic             clr,
    input  logic             upd,
    input  logic             fin,
    input  logic [DAC_W-1:0] dac,
    input  logic [ACC_W-1:0] acc,
    output logic             fit_valid,
    output logic [DAC_W-1:0] fit_dac
);
    logic [ACC_W-1:0] max_q, max_d;
    logic [DAC_W-1:0] cross_q, cross_d;
    logic found_q, found_d, valid_q, valid_d;
    always_comb begin
        max_d   = max_q;
        cross_d = cross_q;
        found_d = found_q;
        valid_d = valid_q | fin;
        if (clr) begin
            max_d   = '0;
            cross_d = '0;
            found_d = 1'b0;
            valid_d = 1'b0;
        end else if (upd && !found_q) begin
            // half-max test done as 2*acc <= max to stay in integers
            if (acc > max_q) max_d = acc;
            else if (max_q != '0 && {acc, 1'b0} <= {1'b0, max_q}) begin
                found_d = 1'b1;
                cross_d = dac;
            end
        end
    end
    always_ff @(posedge clk_int or negedge RSTn_int) begin
        if (!RSTn_int) begin
            max_q   <= '0;
            cross_q <= '0;
            found_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            max_q   <= max_d;
            cross_q <= cross_d;
            found_q <= found_d;
            valid_q <= valid_d;
        end
    end
    assign fit_valid = valid_q;
    assign fit_dac   = !valid_q ? '0 : (found_q ? cross_q : '1);
endmodule
`endif

// File: rtl/ts_scurve_sequencer.sv
// ts_scurve_sequencer: steps the threshold DAC over a range, runs one accumulator window per step and returns (DAC, Acc) pairs.
// Defining SCURVE_FIT_EN adds the half-max crossing fit (FitValid/FitDac).
module ts_scurve_sequencer
    import ts_scurve_pkg::*;
(
    input logic clk_int,
    input logic RSTn_int,
    ts_scurve_sequencer_if.master bus
);
    scan_state_t state_q, state_d;
    logic start_q, start_d;
    logic [DAC_W-1:0] dac_q, dac_d, stop_q, stop_d, res_dac_q, res_dac_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [SETTLE_W-1:0] settle_q, settle_d, cnt_q, cnt_d;
    logic [ACC_W-1:0] res_acc_q, res_acc_d;
    logic res_valid_q, res_valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic start_edge, hs, last_pt;
    logic [DAC_W:0] nxt;
    assign start_edge = bus.Start & ~start_q;
    assign hs         = res_valid_q & bus.ResReady;
    // one extra bit so a step past the top code ends the scan instead of wrapping
    assign nxt        = {1'b0, dac_q} + (DAC_W+1)'(step_q);
    assign last_pt    = nxt > {1'b0, stop_q};
    always_comb begin
        state_d     = state_q;
        start_d     = bus.Start;
        dac_d       = dac_q;
        stop_d      = stop_q;
        step_d      = step_q;
        settle_d    = settle_q;
        cnt_d       = cnt_q;
        res_dac_d   = res_dac_q;
        res_acc_d   = res_acc_q;
        res_valid_d = res_valid_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: if (start_edge) begin
                if (bus.DacStop >= bus.DacStart) begin
                    state_d  = S_SET_DAC;
                    dac_d    = bus.DacStart;
                    stop_d   = bus.DacStop;
                    step_d   = (bus.DacStep == '0) ? STEP_W'(1) : bus.DacStep;
                    settle_d = bus.SettleCyc;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                end else begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            S_SET_DAC: begin
                cnt_d   = '0;
                state_d = bus.Abort ? S_FINISH : (settle_q == '0 ? S_LAUNCH : S_SETTLE);
            end
            S_SETTLE: begin
                cnt_d   = cnt_q + SETTLE_W'(1);
                state_d = bus.Abort ? S_FINISH : (cnt_q == settle_q - SETTLE_W'(1) ? S_LAUNCH : S_SETTLE);
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                cnt_d = cnt_q + SETTLE_W'(1);
                if (bus.AccBusy) state_d = S_WAIT_LO;
                else if (cnt_q == SETTLE_W'(TMO_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_WAIT_LO: if (!bus.AccBusy) begin
                res_acc_d   = bus.Acc;
                res_dac_d   = dac_q;
                res_valid_d = 1'b1;
                state_d     = S_EMIT;
            end
            S_EMIT: if (hs) begin
                res_valid_d = 1'b0;
                state_d     = (bus.Abort || last_pt) ? S_FINISH : S_SET_DAC;
                dac_d       = (bus.Abort || last_pt) ? dac_q : nxt[DAC_W-1:0];
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_int or negedge RSTn_int) begin
        if (!RSTn_int) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            dac_q       <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            settle_q    <= '0;
            cnt_q       <= '0;
            res_dac_q   <= '0;
            res_acc_q   <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            dac_q       <= dac_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            settle_q    <= settle_d;
            cnt_q       <= cnt_d;
            res_dac_q   <= res_dac_d;
            res_acc_q   <= res_acc_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end
    assign bus.DacCode  = dac_q;
    assign bus.AccStart = (state_q == S_LAUNCH);
    assign bus.ResValid = res_valid_q;
    assign bus.ResDac   = res_dac_q;
    assign bus.ResAcc   = res_acc_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Err      = err_q;
`ifdef SCURVE_FIT_EN
    ts_scurve_fit u_fit (
        .clk_int   (clk_int),
        .RSTn_int  (RSTn_int),
        .clr       (start_edge && state_q == S_IDLE),
        .upd       (hs),
        .fin       (state_q == S_FINISH),
        .dac       (res_dac_q),
        .acc       (res_acc_q),
        .fit_valid (bus.FitValid),
        .fit_dac   (bus.FitDac)
    );
`endif
endmodule
